execute_mc: RTL and testbench

Parametrised execute stage for the 5-stage MIPS pipeline. It sits between the ID/EX and EX/MEM pipeline registers and keeps the existing ALU ops, jump target generation and three-level operand forwarding. It adds a single-cycle multiply, an iterative multi-cycle unsigned divide with its own FSM, and an ex_stall_c handshake toward the front end. Forwarding from register 0 is suppressed.

---
 rtl/execute_if.sv | 47 ++++
 rtl/execute_mc.sv | 172 +++++++++++++++++
 tb/tb_execute_mc.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/execute_if.sv
// Execute-stage bus: ID/EX operands, forwarding sources, EX/MEM results and stall handshake.
interface execute_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              mem_stall_c;
  logic              MEM_WB_valid;
  logic [4:0]        MEM_WB_dest;
  logic [DATA_W-1:0] MEM_WB_result;
  logic              WB_WEenable;
  logic [4:0]        WB_dest;
  logic [DATA_W-1:0] WB_value;
  logic [ADDR_W-1:0] ID_EX_nextPC;
  logic [DATA_W-1:0] ID_EX_A;
  logic [DATA_W-1:0] ID_EX_B;
  logic [15:0]       ID_EX_imm;
  logic [4:0]        ID_EX_rs;
  logic [4:0]        ID_EX_rt;
  logic [4:0]        ID_EX_rd;
  logic [5:0]        ID_EX_op;
  logic [1:0]        ID_EX_instruc_type;
  logic [ADDR_W-1:0] EX_MEM_targetPC;
  logic [DATA_W-1:0] EX_MEM_result;
  logic [DATA_W-1:0] EX_MEM_B;
  logic [4:0]        EX_MEM_dest;
  logic [5:0]        EX_MEM_op;
  logic [1:0]        EX_MEM_instruc_type;
  logic              EX_MEM_valid;
  logic              ex_stall_c;
  logic              div_busy;

  modport master (
    output mem_stall_c, MEM_WB_valid, MEM_WB_dest, MEM_WB_result,
           WB_WEenable, WB_dest, WB_value, ID_EX_nextPC, ID_EX_A, ID_EX_B,
           ID_EX_imm, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_op, ID_EX_instruc_type,
    input  EX_MEM_targetPC, EX_MEM_result, EX_MEM_B, EX_MEM_dest, EX_MEM_op,
           EX_MEM_instruc_type, EX_MEM_valid, ex_stall_c, div_busy
  );

  modport slave (
    input  mem_stall_c, MEM_WB_valid, MEM_WB_dest, MEM_WB_result,
           WB_WEenable, WB_dest, WB_value, ID_EX_nextPC, ID_EX_A, ID_EX_B,
           ID_EX_imm, ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_op, ID_EX_instruc_type,
    output EX_MEM_targetPC, EX_MEM_result, EX_MEM_B, EX_MEM_dest, EX_MEM_op,
           EX_MEM_instruc_type, EX_MEM_valid, ex_stall_c, div_busy
  );
endinterface

// File: rtl/execute_mc.sv
// MIPS execute stage: ALU, jump target, 3-level forwarding, 1-cycle multiply,
// and an iterative restoring divider that stalls the front end while it runs.
module execute_mc #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic     clock,
  input  logic     reset,
  execute_if.slave bus
);
  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_MUL = 6'h18;
  localparam logic [5:0] OP_DIV = 6'h1A;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] quot;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] divisor;
  logic              busy;

  logic [ADDR_W-1:0] ex_tpc;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] ex_b;
  logic [4:0]        ex_dest;
  logic [5:0]        ex_op;
  logic [1:0]        ex_type;
  logic              ex_valid;

  logic [DATA_W-1:0] a_fwd;
  logic [DATA_W-1:0] b_fwd;
  logic [DATA_W-1:0] alu_res;
  logic [ADDR_W-1:0] tpc;
  logic [DATA_W:0]   partial;
  logic              ge;
  logic [DATA_W-1:0] rem_n;
  logic              is_div;
  logic              issue;
  logic [4:0]        dest_sel;

  // Youngest matching producer wins; register 0 is never forwarded.
  function automatic logic [DATA_W-1:0] fwd(
    input logic en, input logic [4:0] r, input logic [DATA_W-1:0] rf,
    input logic exv, input logic [4:0] exd, input logic [DATA_W-1:0] exr,
    input logic mwv, input logic [4:0] mwd, input logic [DATA_W-1:0] mwr,
    input logic wbe, input logic [4:0] wbd, input logic [DATA_W-1:0] wbv);
    logic [DATA_W-1:0] v;
    v = rf;
    if (en && r != 5'd0) begin
      if (exv && exd == r)      v = exr;
      else if (mwv && mwd == r) v = mwr;
      else if (wbe && wbd == r) v = wbv;
    end
    return v;
  endfunction

  always_comb begin
    a_fwd = fwd(bus.ID_EX_instruc_type[1], bus.ID_EX_rs, bus.ID_EX_A,
                ex_valid, ex_dest, ex_result,
                bus.MEM_WB_valid, bus.MEM_WB_dest, bus.MEM_WB_result,
                bus.WB_WEenable, bus.WB_dest, bus.WB_value);
    b_fwd = fwd(bus.ID_EX_instruc_type[1], bus.ID_EX_rt, bus.ID_EX_B,
                ex_valid, ex_dest, ex_result,
                bus.MEM_WB_valid, bus.MEM_WB_dest, bus.MEM_WB_result,
                bus.WB_WEenable, bus.WB_dest, bus.WB_value);
  end

  always_comb begin
    alu_res = '0;
    tpc     = bus.ID_EX_nextPC;
    case (bus.ID_EX_op)
      OP_LUI:       alu_res = DATA_W'({bus.ID_EX_imm, 16'h0000});
      OP_ORI:       alu_res = a_fwd | DATA_W'(bus.ID_EX_imm);
      OP_ADD:       alu_res = a_fwd + b_fwd;
      OP_MUL:       alu_res = a_fwd * b_fwd;
      OP_LW, OP_SW: alu_res = a_fwd + {{(DATA_W-16){bus.ID_EX_imm[15]}}, bus.ID_EX_imm};
      OP_J:         tpc = {bus.ID_EX_nextPC[ADDR_W-1:28], bus.ID_EX_rs, bus.ID_EX_rt,
                           bus.ID_EX_imm, 2'b00};
      default:      alu_res = '0;
    endcase
  end

  // One restoring step: shift next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    partial = {rem, quot[DATA_W-1]};
    ge      = partial >= {1'b0, divisor};
    rem_n   = ge ? DATA_W'(partial - {1'b0, divisor}) : partial[DATA_W-1:0];
  end

  assign is_div   = (bus.ID_EX_op == OP_DIV) && (bus.ID_EX_instruc_type != 2'b00);
  assign issue    = (state == IDLE) && is_div;
  assign dest_sel = (bus.ID_EX_instruc_type == 2'b11) ? bus.ID_EX_rd : bus.ID_EX_rt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      quot      <= '0;
      rem       <= '0;
      divisor   <= '0;
      busy      <= 1'b0;
      ex_tpc    <= '0;
      ex_result <= '0;
      ex_b      <= '0;
      ex_dest   <= '0;
      ex_op     <= '0;
      ex_type   <= '0;
      ex_valid  <= 1'b0;
    end else if (!bus.mem_stall_c) begin
      case (state)
        IDLE: begin
          if (is_div) begin
            quot     <= a_fwd;
            rem      <= '0;
            divisor  <= b_fwd;
            cnt      <= CNT_W'(DIV_CYCLES - 1);
            busy     <= 1'b1;
            ex_valid <= 1'b0;
            state    <= BUSY;
          end else begin
            ex_tpc    <= tpc;
            ex_result <= alu_res;
            ex_b      <= b_fwd;
            ex_dest   <= dest_sel;
            ex_op     <= bus.ID_EX_op;
            ex_type   <= bus.ID_EX_instruc_type;
            ex_valid  <= bus.ID_EX_instruc_type != 2'b00;
          end
        end
        BUSY: begin
          rem      <= rem_n;
          quot     <= {quot[DATA_W-2:0], ge};
          ex_valid <= 1'b0;
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        DONE: begin
          ex_tpc    <= bus.ID_EX_nextPC;
          ex_result <= quot;
          ex_b      <= divisor;
          ex_dest   <= dest_sel;
          ex_op     <= bus.ID_EX_op;
          ex_type   <= bus.ID_EX_instruc_type;
          ex_valid  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ex_stall_c          = bus.mem_stall_c | issue | (state == BUSY);
  assign bus.div_busy            = busy;
  assign bus.EX_MEM_targetPC     = ex_tpc;
  assign bus.EX_MEM_result       = ex_result;
  assign bus.EX_MEM_B            = ex_b;
  assign bus.EX_MEM_dest         = ex_dest;
  assign bus.EX_MEM_op           = ex_op;
  assign bus.EX_MEM_instruc_type = ex_type;
  assign bus.EX_MEM_valid        = ex_valid;
endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: ALU/forwarding vector table plus divider sequences.
module tb_execute_mc;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_ORI = 6'h0D;
  localparam logic [5:0] OP_LUI = 6'h0F;
  localparam logic [5:0] OP_MUL = 6'h18;
  localparam logic [5:0] OP_DIV = 6'h1A;
  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [31:0] NPC   = 32'h0040_0010;

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  ty;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b;
    logic [15:0] imm;
    logic [31:0] npc;
    logic        mw_v;
    logic [4:0]  mw_d;
    logic [31:0] mw_r;
    logic        wb_e;
    logic [4:0]  wb_d;
    logic [31:0] wb_v;
    logic [31:0] e_res, e_b, e_tpc;
    logic [4:0]  e_dest;
    logic        e_valid;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  vec_t vt[13];
  vec_t vm;

  execute_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  execute_mc #(.DATA_W(32), .ADDR_W(32), .DIV_CYCLES(32)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [1:0] ty,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
      input logic [31:0] e_res, input logic [31:0] e_b, input logic [4:0] e_dest,
      input logic e_valid);
    vec_t x;
    x.op = op; x.ty = ty; x.rs = rs; x.rt = rt; x.rd = rd;
    x.a = a; x.b = b; x.imm = imm; x.npc = NPC;
    x.mw_v = 1'b0; x.mw_d = 5'd0; x.mw_r = 32'd0;
    x.wb_e = 1'b0; x.wb_d = 5'd0; x.wb_v = 32'd0;
    x.e_res = e_res; x.e_b = e_b; x.e_tpc = NPC; x.e_dest = e_dest; x.e_valid = e_valid;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    bus.ID_EX_op = x.op; bus.ID_EX_instruc_type = x.ty;
    bus.ID_EX_rs = x.rs; bus.ID_EX_rt = x.rt; bus.ID_EX_rd = x.rd;
    bus.ID_EX_A = x.a; bus.ID_EX_B = x.b; bus.ID_EX_imm = x.imm; bus.ID_EX_nextPC = x.npc;
    bus.MEM_WB_valid = x.mw_v; bus.MEM_WB_dest = x.mw_d; bus.MEM_WB_result = x.mw_r;
    bus.WB_WEenable = x.wb_e; bus.WB_dest = x.wb_d; bus.WB_value = x.wb_v;
  endtask

  task automatic bubble();
    drive(mk(6'h00, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 32'd0, 32'd0, 5'd0, 1'b0));
  endtask

  task automatic apply_vec(input vec_t x, input string nm);
    @(negedge clock);
    drive(x);
    @(posedge clock);
    #1;
    chk({nm, ".result"}, bus.EX_MEM_result, x.e_res);
    chk({nm, ".B"}, bus.EX_MEM_B, x.e_b);
    chk({nm, ".dest"}, 32'(bus.EX_MEM_dest), 32'(x.e_dest));
    chk({nm, ".valid"}, 32'(bus.EX_MEM_valid), 32'(x.e_valid));
    chk({nm, ".tpc"}, bus.EX_MEM_targetPC, x.e_tpc);
  endtask

  // Issue a div r22 = r20 / r21 and track it to commit, optionally with a MEM stall window.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         input int stall_at, input int stall_len, input string nm);
    int   edges;
    int   stalls;
    logic got;
    logic done_now;
    logic seen_done;
    @(negedge clock);
    drive(mk(OP_DIV, 2'b11, 5'd20, 5'd21, 5'd22, a, b, 16'd0, 32'd0, 32'd0, 5'd0, 1'b0));
    bus.mem_stall_c = 1'b0;
    #1;
    edges = 0; stalls = 0; got = 1'b0; seen_done = 1'b0;
    while (!got && edges < 200) begin
      done_now = bus.div_busy && !bus.ex_stall_c;
      if (done_now) seen_done = 1'b1;
      if (bus.ex_stall_c && !bus.mem_stall_c) stalls++;
      @(posedge clock);
      edges++;
      #1;
      if (done_now) bubble();
      if (edges == 1) begin
        bus.WB_WEenable = 1'b1; bus.WB_dest = 5'd20; bus.WB_value = 32'hDEAD_0001;
      end
      if (stall_len > 0 && edges == stall_at) bus.mem_stall_c = 1'b1;
      if (stall_len > 0 && edges == stall_at + stall_len) bus.mem_stall_c = 1'b0;
      got = bus.EX_MEM_valid;
      #1;
    end
    chk({nm, ".latency"}, 32'(edges), 32'(34 + stall_len));
    chk({nm, ".quotient"}, bus.EX_MEM_result, q);
    chk({nm, ".dest"}, 32'(bus.EX_MEM_dest), 32'd22);
    chk({nm, ".op"}, 32'(bus.EX_MEM_op), 32'(OP_DIV));
    chk({nm, ".stall_cycles"}, 32'(stalls), 32'd33);
    chk({nm, ".done_unstalled"}, 32'(seen_done), 32'd1);
    chk({nm, ".busy_after"}, 32'(bus.div_busy), 32'd0);
    bubble();
    bus.mem_stall_c = 1'b0;
  endtask

  initial begin
    vt[0]  = mk(OP_LUI, 2'b01, 5'd0, 5'd4, 5'd0, 32'd0, 32'd0, 16'h1234, 32'h1234_0000, 32'd0, 5'd4, 1'b1);
    vt[1]  = mk(OP_ORI, 2'b01, 5'd0, 5'd1, 5'd0, 32'd5, 32'd0, 16'h0000, 32'd5, 32'd0, 5'd1, 1'b1);
    vt[2]  = mk(OP_ADD, 2'b11, 5'd1, 5'd2, 5'd3, 32'h100, 32'h200, 16'h0000, 32'd12, 32'd7, 5'd3, 1'b1);
    vt[2].mw_v = 1'b1; vt[2].mw_d = 5'd1; vt[2].mw_r = 32'd9;
    vt[2].wb_e = 1'b1; vt[2].wb_d = 5'd2; vt[2].wb_v = 32'd7;
    vt[3]  = mk(OP_ORI, 2'b01, 5'd0, 5'd0, 5'd0, 32'hFF, 32'd0, 16'h0000, 32'hFF, 32'd0, 5'd0, 1'b1);
    vt[4]  = mk(OP_ORI, 2'b10, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0, 16'h0001, 32'd1, 32'd0, 5'd5, 1'b1);
    vt[4].mw_v = 1'b1; vt[4].mw_d = 5'd0; vt[4].mw_r = 32'h55;
    vt[4].wb_e = 1'b1; vt[4].wb_d = 5'd0; vt[4].wb_v = 32'h77;
    vt[5]  = mk(OP_LW, 2'b10, 5'd6, 5'd7, 5'd0, 32'h1000, 32'd0, 16'hFFFC, 32'h1FFC, 32'd0, 5'd7, 1'b1);
    vt[5].mw_v = 1'b1; vt[5].mw_d = 5'd6; vt[5].mw_r = 32'h2000;
    vt[5].wb_e = 1'b1; vt[5].wb_d = 5'd6; vt[5].wb_v = 32'h3000;
    vt[6]  = mk(OP_SW, 2'b10, 5'd7, 5'd8, 5'd0, 32'd0, 32'd0, 16'h0010, 32'h200C, 32'hABCD, 5'd8, 1'b1);
    vt[6].wb_e = 1'b1; vt[6].wb_d = 5'd8; vt[6].wb_v = 32'hABCD;
    vt[7]  = mk(OP_J, 2'b01, 5'd3, 5'd5, 5'd0, 32'd0, 32'd0, 16'h0100, 32'd0, 32'd0, 5'd5, 1'b1);
    vt[7].npc = 32'hA000_0004; vt[7].e_tpc = 32'hA194_0400;
    vt[8]  = mk(OP_ADD, 2'b00, 5'd1, 5'd9, 5'd2, 32'd1, 32'd2, 16'h0000, 32'd3, 32'd2, 5'd9, 1'b0);
    vt[9]  = mk(OP_MUL, 2'b11, 5'd10, 5'd11, 5'd12, 32'h10000, 32'h10000, 16'h0000, 32'd0, 32'h10000, 5'd12, 1'b1);
    vt[10] = mk(OP_MUL, 2'b11, 5'd13, 5'd14, 5'd15, 32'd7, 32'd6, 16'h0000, 32'd42, 32'd6, 5'd15, 1'b1);
    vt[11] = mk(OP_ADD, 2'b11, 5'd16, 5'd17, 5'd18, 32'hFFFF_FFFF, 32'd2, 16'h0000, 32'd1, 32'd2, 5'd18, 1'b1);
    vt[12] = mk(6'h3F, 2'b11, 5'd1, 5'd2, 5'd19, 32'd5, 32'd6, 16'h0000, 32'd0, 32'd6, 5'd19, 1'b1);
    vm     = mk(OP_MUL, 2'b11, 5'd24, 5'd25, 5'd26, 32'h10000, 32'h10000, 16'h0000, 32'd0, 32'h10000, 5'd26, 1'b1);

    bus.mem_stall_c = 1'b0;
    bubble();
    #1;
    chk("reset.result", bus.EX_MEM_result, 32'd0);
    chk("reset.valid", 32'(bus.EX_MEM_valid), 32'd0);
    chk("reset.tpc", bus.EX_MEM_targetPC, 32'd0);
    chk("reset.busy", 32'(bus.div_busy), 32'd0);
    chk("reset.stall", 32'(bus.ex_stall_c), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) apply_vec(vt[i], $sformatf("vec%0d", i));

    // MEM stall must freeze EX_MEM even with a new instruction presented.
    @(negedge clock);
    drive(vt[0]);
    bus.mem_stall_c = 1'b1;
    @(posedge clock);
    #1;
    chk("hold.dest", 32'(bus.EX_MEM_dest), 32'd19);
    chk("hold.op", 32'(bus.EX_MEM_op), 32'h3F);
    chk("hold.stall", 32'(bus.ex_stall_c), 32'd1);
    bus.mem_stall_c = 1'b0;

    run_div(32'd100, 32'd7, 32'd14, 0, 0, "div100_7");
    run_div(32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, "div5_0");
    apply_vec(vm, "mul_after_div");
    run_div(32'd100, 32'd7, 32'd14, 5, 3, "div_memstall");

    // Async reset pulse in the middle of a divide.
    @(negedge clock);
    drive(mk(OP_DIV, 2'b11, 5'd20, 5'd21, 5'd22, 32'd50, 32'd5, 16'd0, 32'd0, 32'd0, 5'd0, 1'b0));
    repeat (10) @(posedge clock);
    #2;
    chk("midreset.busy_before", 32'(bus.div_busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("midreset.result", bus.EX_MEM_result, 32'd0);
    chk("midreset.dest", 32'(bus.EX_MEM_dest), 32'd0);
    chk("midreset.valid", 32'(bus.EX_MEM_valid), 32'd0);
    chk("midreset.busy", 32'(bus.div_busy), 32'd0);
    bubble();
    reset = 1'b0;

    run_div(32'd9, 32'd3, 32'd3, 0, 0, "div9_3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
